// File: rtl/tx_gearbox66_pkg.sv
// Shared 64b/66b gearbox definitions (package gbox_pkg), used by the transmit gearbox and the receive path.
package gbox_pkg;

    localparam logic [1:0] C_DATA_HEADER = 2'b01;
    localparam logic [1:0] C_CMD_HEADER  = 2'b10;

    localparam int C_HDR_W     = 2;
    localparam int C_BLK_W     = 66;
    localparam int C_PAYLOAD_W = 64;
    localparam int C_WORD_W    = 32;
    localparam int C_BUF_W     = 97;
    localparam int C_FILL_W    = 7;

    localparam int          C_SCR_W     = 58;
    localparam int          C_SCR_TAP_A = 38;
    localparam int          C_SCR_TAP_B = 57;
    localparam logic [57:0] C_SCR_INIT  = '1;

    function automatic logic hdr_legal(input logic [C_HDR_W-1:0] hdr);
        return (hdr == C_DATA_HEADER) || (hdr == C_CMD_HEADER);
    endfunction

endpackage

// File: rtl/tx_gearbox66_if.sv
// Block-in / word-out bundle of the transmit gearbox; master is the framer/serializer side, slave the gearbox.
interface tx_gearbox66_if;
    import gbox_pkg::*;

    logic [C_PAYLOAD_W-1:0] blk_data_i;
    logic [C_HDR_W-1:0]     blk_hdr_i;
    logic                   blk_valid_i;
    logic                   blk_ready_o;
    logic [C_WORD_W-1:0]    tx_word_o;
    logic                   tx_valid_o;
    logic                   tx_ready_i;
    logic                   hdr_err_o;
    logic                   underflow_o;

    modport master (
        output blk_data_i, blk_hdr_i, blk_valid_i, tx_ready_i,
        input  blk_ready_o, tx_word_o, tx_valid_o, hdr_err_o, underflow_o
    );

    modport slave (
        input  blk_data_i, blk_hdr_i, blk_valid_i, tx_ready_i,
        output blk_ready_o, tx_word_o, tx_valid_o, hdr_err_o, underflow_o
    );

endinterface

// File: rtl/tx_scrambler58.sv
// Self-synchronous 1 + x^39 + x^58 payload scrambler, 64 bits per advance, bit 63 first.
module tx_scrambler58
    import gbox_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   advance,
    input  logic [C_PAYLOAD_W-1:0] raw,
    output logic [C_PAYLOAD_W-1:0] scrambled
);

    logic [C_SCR_W-1:0] state_q;
    logic [C_SCR_W-1:0] state_next;

    // state_next[0] always holds the most recently scrambled bit
    always_comb begin
        state_next = state_q;
        scrambled  = '0;
        for (int i = C_PAYLOAD_W - 1; i >= 0; i--) begin
            scrambled[i] = raw[i] ^ state_next[C_SCR_TAP_A] ^ state_next[C_SCR_TAP_B];
            state_next   = {state_next[C_SCR_W-2:0], scrambled[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_SCR_INIT;
        end else if (advance) begin
            state_q <= state_next;
        end
    end

endmodule

// File: rtl/tx_gearbox66.sv
// 66-bit block to 32-bit word transmit gearbox, MSB first.
// Define TX_GBOX_SCRAMBLER_EN to scramble the payload (never the header) before buffering.
module tx_gearbox66
    import gbox_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    tx_gearbox66_if.slave  bus
);

    logic [C_BUF_W-1:0]     buf_q;
    logic [C_FILL_W-1:0]    fill_q;
    logic                   started_q;
    logic                   hdr_err_q;
    logic                   underflow_q;
    logic                   ready;
    logic                   valid;
    logic                   accept;
    logic                   drain;
    logic [C_PAYLOAD_W-1:0] payload;
    logic [C_BUF_W-1:0]     blk_placed;

    // Accept needs fill <= 31 and drain needs fill >= 32, so they are mutually exclusive
    assign ready  = (fill_q <= 7'd31);
    assign valid  = (fill_q >= 7'd32);
    assign accept = bus.blk_valid_i & ready;
    assign drain  = valid & bus.tx_ready_i;

`ifdef TX_GBOX_SCRAMBLER_EN
    tx_scrambler58 u_scrambler (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .advance   (accept),
        .raw       (bus.blk_data_i),
        .scrambled (payload)
    );
`else
    assign payload = bus.blk_data_i;
`endif

    // Bits below fill_q are always zero, so OR-ing the shifted block appends it
    assign blk_placed = {bus.blk_hdr_i, payload, {(C_BUF_W - C_BLK_W){1'b0}}} >> fill_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q       <= '0;
            fill_q      <= '0;
            started_q   <= 1'b0;
            hdr_err_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            hdr_err_q   <= accept & ~hdr_legal(bus.blk_hdr_i);
            underflow_q <= started_q & bus.tx_ready_i & ~valid;
            if (accept) begin
                buf_q     <= buf_q | blk_placed;
                fill_q    <= fill_q + 7'd66;
                started_q <= 1'b1;
            end else if (drain) begin
                buf_q  <= buf_q << C_WORD_W;
                fill_q <= fill_q - 7'd32;
            end
        end
    end

    assign bus.blk_ready_o = ready;
    assign bus.tx_valid_o  = valid;
    assign bus.tx_word_o   = buf_q[C_BUF_W-1 -: C_WORD_W];
    assign bus.hdr_err_o   = hdr_err_q;
    assign bus.underflow_o = underflow_q;

endmodule

// File: tb/tb_tx_gearbox66.sv
// Directed bench for tx_gearbox66 with a bit-level scoreboard and a 66-bit deserializer.
module tb_tx_gearbox66;
    import gbox_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tx_gearbox66_if bus ();

    tx_gearbox66 dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int   tests = 0;
    int   fails = 0;
    bit   exp_q[$];
    bit   rx_q[$];
    logic deser_en = 1'b0;
    int   hdr_seen = 0;
    logic [31:0] exp_word;
    logic [63:0] exp_pay;
    logic [1:0]  rx_hdr;
`ifdef TX_GBOX_SCRAMBLER_EN
    logic [57:0] scr_s = '1;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] payload_model(input logic [63:0] d);
`ifdef TX_GBOX_SCRAMBLER_EN
        logic [63:0] o;
        o = '0;
        for (int i = 63; i >= 0; i--) begin
            o[i]  = d[i] ^ scr_s[38] ^ scr_s[57];
            scr_s = {scr_s[56:0], o[i]};
        end
        return o;
`else
        return d;
`endif
    endfunction

    // Scoreboard: transfers are decided at the next posedge, so sample on the negedge before it
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.blk_valid_i && bus.blk_ready_o) begin
                exp_q.push_back(bus.blk_hdr_i[1]);
                exp_q.push_back(bus.blk_hdr_i[0]);
                exp_pay = payload_model(bus.blk_data_i);
                for (int i = 63; i >= 0; i--) exp_q.push_back(exp_pay[i]);
            end
            if (bus.tx_valid_o && bus.tx_ready_i) begin
                if (exp_q.size() < 32) begin
                    check("sb_underrun", 64'(exp_q.size()), 64'd32);
                end else begin
                    for (int i = 31; i >= 0; i--) exp_word[i] = exp_q.pop_front();
                    check("sb_word", bus.tx_word_o, exp_word);
                end
                if (deser_en) begin
                    for (int i = 31; i >= 0; i--) rx_q.push_back(bus.tx_word_o[i]);
                    while (rx_q.size() >= 66) begin
                        rx_hdr = {rx_q[0], rx_q[1]};
                        check("deser_hdr", hdr_legal(rx_hdr), 1);
                        hdr_seen++;
                        for (int i = 0; i < 66; i++) void'(rx_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        rx_q.delete();
        deser_en = 1'b0;
        bus.blk_valid_i = 1'b0;
`ifdef TX_GBOX_SCRAMBLER_EN
        scr_s = '1;
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Offers one block and returns at posedge+1 of the accepting edge
    task automatic send(input logic [1:0] h, input logic [63:0] d);
        logic done;
        done = 1'b0;
        bus.blk_hdr_i   = h;
        bus.blk_data_i  = d;
        bus.blk_valid_i = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            done = bus.blk_ready_o;
            tick();
        end
        bus.blk_valid_i = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    logic [63:0] d;
    logic [31:0] w;
    logic        acc;
    int          n_acc;

    initial begin
        bus.blk_data_i  = '0;
        bus.blk_hdr_i   = '0;
        bus.blk_valid_i = 1'b0;
        bus.tx_ready_i  = 1'b0;
        #2;

        // Reset state
        check("rst_word", bus.tx_word_o, 0);
        check("rst_valid", bus.tx_valid_o, 0);
        check("rst_ready", bus.blk_ready_o, 1);
        check("rst_hdr_err", bus.hdr_err_o, 0);
        check("rst_underflow", bus.underflow_o, 0);
        do_reset();

        // Single block and underflow
        bus.tx_ready_i = 1'b1;
        send(2'b01, 64'h0123_4567_89AB_CDEF);
        check("single_valid0", bus.tx_valid_o, 1);
`ifndef TX_GBOX_SCRAMBLER_EN
        check("single_word0", bus.tx_word_o, 32'h4048_D159);
`else
        check("single_hdr", bus.tx_word_o[31:30], 2'b01);
`endif
        tick();
        check("single_valid1", bus.tx_valid_o, 1);
`ifndef TX_GBOX_SCRAMBLER_EN
        check("single_word1", bus.tx_word_o, 32'hE26A_F37B);
`endif
        tick();
        check("single_valid2", bus.tx_valid_o, 0);
        check("underflow_early", bus.underflow_o, 0);
        tick();
        check("underflow_pulse", bus.underflow_o, 1);
        bus.tx_ready_i = 1'b0;
        tick();
        check("underflow_clear", bus.underflow_o, 0);

        // Reset in the middle of a block
        bus.tx_ready_i = 1'b1;
        send(2'b10, 64'hFEDC_BA98_7654_3210);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", bus.tx_valid_o, 0);
        check("midrst_word", bus.tx_word_o, 0);
        check("midrst_ready", bus.blk_ready_o, 1);
        check("midrst_underflow", bus.underflow_o, 0);
        do_reset();
        d = {$urandom, $urandom};
        send(2'b01, d);
        check("postrst_hdr", bus.tx_word_o[31:30], 2'b01);
`ifndef TX_GBOX_SCRAMBLER_EN
        check("postrst_word", bus.tx_word_o, {2'b01, d[63:34]});
`endif
        tick();
        tick();

        // Illegal header
        do_reset();
        bus.tx_ready_i = 1'b1;
        send(2'b11, {$urandom, $urandom});
        check("illegal_err", bus.hdr_err_o, 1);
        check("illegal_bits", bus.tx_word_o[31:30], 2'b11);
        tick();
        check("illegal_err_clear", bus.hdr_err_o, 0);
        tick();
        tick();

        // Backpressure at fill 66
        do_reset();
        bus.tx_ready_i = 1'b0;
        send(2'b10, {$urandom, $urandom});
        for (int i = 0; i < 32; i++) w[31-i] = exp_q[i];
        for (int i = 0; i < 10; i++) begin
            check("bp_ready", bus.blk_ready_o, 0);
            check("bp_word", bus.tx_word_o, w);
            tick();
        end
        bus.tx_ready_i = 1'b1;
        send(2'b01, {$urandom, $urandom});
        send(2'b10, {$urandom, $urandom});
        for (int i = 0; i < 8; i++) tick();

        // Continuous stream with alternating headers
        do_reset();
        deser_en = 1'b1;
        hdr_seen = 0;
        n_acc = 0;
        bus.tx_ready_i  = 1'b1;
        bus.blk_hdr_i   = 2'b01;
        bus.blk_data_i  = {$urandom, $urandom};
        bus.blk_valid_i = 1'b1;
        for (int c = 0; c < 200; c++) begin
            acc = bus.blk_ready_o;
            tick();
            if (acc) begin
                n_acc++;
                bus.blk_hdr_i  = (bus.blk_hdr_i == 2'b01) ? 2'b10 : 2'b01;
                bus.blk_data_i = {$urandom, $urandom};
            end
        end
        bus.blk_valid_i = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("stream_blocks", (n_acc > 0) && (hdr_seen >= n_acc - 1) && (hdr_seen <= n_acc), 1);
        deser_en = 1'b0;

`ifdef TX_GBOX_SCRAMBLER_EN
        // Scrambler with zero payload
        do_reset();
        bus.tx_ready_i = 1'b1;
        send(2'b01, 64'h0);
        check("scr_hdr", bus.tx_word_o[31:30], 2'b01);
        for (int i = 0; i < 3; i++) send(2'b10, 64'h0);
        for (int i = 0; i < 8; i++) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
